// File: rtl/fu_arb_pkg.sv
// fu_share_arb shared types and widths.
// Optional grant statistics: FU_ARB_STATS_EN.
package fu_arb_pkg;

  localparam int NREQ = 2;
  localparam int OPW  = 2;
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/fu_share_arb_rr_pick2.sv
// Two-way round-robin picker.
// prio selects the winner only when both requesters are valid.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       any
);

  // one-hot grant, priority token breaks ties
  assign gnt[0] = valid[0] & (~valid[1] | ~prio);
  assign gnt[1] = valid[1] & (~valid[0] |  prio);
  assign any    = |valid;

endmodule

// File: rtl/fu_share_arb.sv
// Round-robin scheduler for one shared 2-bit function unit.
// FU_ARB_STATS_EN adds saturating per-requester grant counters.
module fu_share_arb
  import fu_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [3:0]      req_a,
  input  logic [3:0]      req_b,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  output logic [OPW-1:0]  rsp_c,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [OPW-1:0]  fu_a,
  output logic [OPW-1:0]  fu_b,
  input  logic [OPW-1:0]  fu_c
`ifdef FU_ARB_STATS_EN
  ,
  output logic [CNTW-1:0] grant_cnt0,
  output logic [CNTW-1:0] grant_cnt1
`endif
);

  state_e          state;
  logic            prio;
  logic            owner;
  logic [OPW-1:0]  op_a;
  logic [OPW-1:0]  op_b;
  logic [OPW-1:0]  res;
  logic [NREQ-1:0] rsp_vld_q;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic            win;
  logic            idle_ok;
  logic [OPW-1:0]  sel_a;
  logic [OPW-1:0]  sel_b;

  rr_pick2 u_pick (
    .valid (req_valid),
    .prio  (prio),
    .gnt   (gnt),
    .any   (any)
  );

  assign win     = gnt[1];
  assign sel_a   = win ? req_a[3:2] : req_a[1:0];
  assign sel_b   = win ? req_b[3:2] : req_b[1:0];
  // reset held low must not advertise an accept
  assign idle_ok = (state == IDLE) & rst_n;

  assign req_ready = idle_ok ? gnt : '0;
  assign rsp_valid = rsp_vld_q;
  assign rsp_c     = res;
  assign fu_a      = op_a;
  assign fu_b      = op_b;

  // accept -> drive unit -> hold result until owner takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      rsp_vld_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            owner <= win;
            state <= EXEC;
          end
        end
        EXEC: begin
          res       <= fu_c;
          rsp_vld_q <= owner ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_vld_q <= '0;
            prio      <= ~owner;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FU_ARB_STATS_EN
  logic [CNTW-1:0] cnt0;
  logic [CNTW-1:0] cnt1;

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;

  // saturating accept counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (state == IDLE) begin
      if (gnt[0] && cnt0 != '1)
        cnt0 <= cnt0 + 1'b1;
      if (gnt[1] && cnt1 != '1)
        cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fu_share_arb.sv
// Self-checking bench for fu_share_arb.
// Directed scenarios then random traffic against a transaction model.
module tb_fu_share_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_c;
  logic [1:0] rsp_ready;
  logic [1:0] fu_a;
  logic [1:0] fu_b;
  logic [1:0] fu_c;
`ifdef FU_ARB_STATS_EN
  logic [7:0] grant_cnt0;
  logic [7:0] grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // model of the shared unit
  function automatic logic [1:0] fu_f(input logic [1:0] a, input logic [1:0] b);
    return {a[0] | b[1], b[0]};
  endfunction

  assign fu_c = fu_f(fu_a, fu_b);

  always #5 clk = ~clk;

  fu_share_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_c     (rsp_c),
    .rsp_ready (rsp_ready),
    .fu_a      (fu_a),
    .fu_b      (fu_b),
    .fu_c      (fu_c)
`ifdef FU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // transaction-level reference: one job in flight, age in cycles
  bit         pend;
  int         age;
  bit         m_prio;
  bit         m_own;
  logic [1:0] m_fa;
  logic [1:0] m_fb;
  logic [1:0] m_c;
  int         m_cnt0;
  int         m_cnt1;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend   = 0;
    age    = 0;
    m_prio = 0;
    m_own  = 0;
    m_fa   = 2'b00;
    m_fb   = 2'b00;
    m_c    = 2'b00;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // called at negedge with inputs applied: check, clock, update model
  task automatic cycle();
    bit         w;
    logic [1:0] exp_rr;
    logic [1:0] exp_rv;
    #1;
    w = (req_valid == 2'b11) ? m_prio : req_valid[1];
    exp_rr = 2'b00;
    if (!pend && rst_n && req_valid != 2'b00)
      exp_rr = w ? 2'b10 : 2'b01;
    exp_rv = 2'b00;
    if (pend && age >= 2)
      exp_rv = m_own ? 2'b10 : 2'b01;
    chk("req_ready", {6'd0, req_ready}, {6'd0, exp_rr});
    chk("rsp_valid", {6'd0, rsp_valid}, {6'd0, exp_rv});
    chk("fu_a", {6'd0, fu_a}, {6'd0, m_fa});
    chk("fu_b", {6'd0, fu_b}, {6'd0, m_fb});
    if (exp_rv != 2'b00)
      chk("rsp_c", {6'd0, rsp_c}, {6'd0, m_c});
`ifdef FU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, m_cnt0[7:0]);
    chk("grant_cnt1", grant_cnt1, m_cnt1[7:0]);
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (!pend) begin
      if (req_valid != 2'b00) begin
        pend  = 1;
        age   = 1;
        m_own = w;
        m_fa  = w ? req_a[3:2] : req_a[1:0];
        m_fb  = w ? req_b[3:2] : req_b[1:0];
        m_c   = fu_f(m_fa, m_fb);
        if (w) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
        else   m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
      end
    end else if (age == 1) begin
      age = 2;
    end else if (rsp_ready[m_own]) begin
      pend   = 0;
      m_prio = ~m_own;
    end else begin
      age++;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = 4'hF;
    req_b     = 4'hF;
    rsp_ready = 2'b00;
    @(posedge clk);
    @(negedge clk);

    // reset held with both requesters valid
    cycle();
    cycle();
    #1;
    chk("rst_req_ready", {6'd0, req_ready}, 8'h00);
    chk("rst_rsp_valid", {6'd0, rsp_valid}, 8'h00);
    chk("rst_rsp_c", {6'd0, rsp_c}, 8'h00);
    chk("rst_fu_a", {6'd0, fu_a}, 8'h00);
    @(negedge clk);

    // single request from r0
    rst_n     = 1'b1;
    req_valid = 2'b01;
    req_a     = 4'b0001;
    req_b     = 4'b0000;
    rsp_ready = 2'b11;
    cycle();
    req_valid = 2'b00;
    cycle();
    #1;
    chk("single_vld", {6'd0, rsp_valid}, 8'h01);
    chk("single_c", {6'd0, rsp_c}, 8'h02);
    cycle();
    cycle();

    // contention straight after reset
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    req_valid = 2'b11;
    req_a     = 4'b1011;
    req_b     = 4'b1110;
    #1;
    chk("cont_first", {6'd0, req_ready}, 8'h01);
    cycle();
    cycle();
    #1;
    chk("cont_r0_vld", {6'd0, rsp_valid}, 8'h01);
    chk("cont_r0_c", {6'd0, rsp_c}, 8'h02);
    cycle();
    #1;
    chk("cont_second", {6'd0, req_ready}, 8'h02);
    cycle();
    req_valid = 2'b00;
    cycle();
    #1;
    chk("cont_r1_vld", {6'd0, rsp_valid}, 8'h02);
    chk("cont_r1_c", {6'd0, rsp_c}, 8'h03);
    cycle();
    cycle();

    // backpressure on r1's response
    req_valid = 2'b10;
    req_a     = 4'b0100;
    req_b     = 4'b1100;
    rsp_ready = 2'b00;
    cycle();
    req_valid = 2'b00;
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    rsp_ready = 2'b01;
    cycle();
    #1;
    chk("bp_hold_vld", {6'd0, rsp_valid}, 8'h02);
    chk("bp_hold_c", {6'd0, rsp_c}, 8'h03);
    rsp_ready = 2'b10;
    cycle();
    #1;
    chk("bp_done", {6'd0, rsp_valid}, 8'h00);
    cycle();

    // reset while the unit is executing
    rsp_ready = 2'b11;
    req_valid = 2'b10;
    req_a     = 4'b1100;
    req_b     = 4'b0100;
    cycle();
    req_valid = 2'b00;
    rst_n     = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    #1;
    chk("rexec_vld", {6'd0, rsp_valid}, 8'h00);
    req_valid = 2'b11;
    #1;
    chk("rexec_prio", {6'd0, req_ready}, 8'h01);
    req_valid = 2'b00;
    cycle();

`ifdef FU_ARB_STATS_EN
    // r1 back-to-back until its counter saturates
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    req_valid = 2'b10;
    rsp_ready = 2'b11;
    for (int i = 0; i < 300 * 3; i++) begin
      req_a = 4'($urandom);
      req_b = 4'($urandom);
      cycle();
    end
    #1;
    chk("sat_cnt1", grant_cnt1, 8'd255);
    chk("sat_cnt0", grant_cnt0, 8'd0);
    req_valid = 2'b00;
    cycle();
`endif

    // random traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 60) != 0);
      req_valid = 2'($urandom);
      req_a     = 4'($urandom);
      req_b     = 4'($urandom);
      rsp_ready = 2'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
